ladybird_serial_loader: RTL and testbench
=========================================

# ladybird_serial_loader

Byte-stream command decoder between the UART serial interface and the memory/bus side of the ladybird design. It consumes received bytes from the serial interface's output handshake, assembles little-endian 32-bit address/data words, and issues single-word memory read or write requests. It returns response bytes to the serial interface's transmit input, so a host can load and inspect memory over the UART link.

## Interface
Parameters:
- TIMEOUT, 32'd10_000_000, inter-byte timeout in clk cycles; used only when LADYBIRD_LOADER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- anrst  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from the serial interface.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte.
- tx_data  out  8  response byte to the serial interface.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  serial interface accepts the byte.
- mem_addr  out  32  request address.
- mem_wdata  out  32  write data.
- mem_we  out  1  1 = write, 0 = read.
- mem_valid  out  1  request valid.
- mem_ready  in  1  request accepted.
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  read data valid, single-cycle pulse.

## Operation
- Byte transfer: rx_valid & rx_ready. Tx transfer: tx_valid & tx_ready. Mem request transfer: mem_valid & mem_ready.
- States: IDLE, ADDR, DATA, REQ, WAIT_R, RESP. A 2-bit byte counter is used in ADDR, DATA and RESP.
- IDLE:
  - Byte 0x57 ('W') → ADDR with we=1.
  - Byte 0x52 ('R') → ADDR with we=0.
  - Any other byte is consumed and dropped; state stays IDLE.
- ADDR: 4 bytes, LSB first, into addr[8k+7:8k]. After the 4th byte → DATA if we, else → REQ.
- DATA: 4 bytes, LSB first, into wdata. After the 4th byte → REQ.
- REQ:
  - mem_valid=1. mem_addr, mem_wdata and mem_we are held stable until the transfer.
  - On transfer with we=1 → RESP with the single byte 0x06.
  - On transfer with we=0 → WAIT_R.
- WAIT_R: on mem_rvalid, capture mem_rdata → RESP with 4 bytes, LSB first. mem_rvalid is ignored in every other state.
- RESP:
  - tx_valid=1; tx_data is held stable until the transfer.
  - Counter advances per transfer. After the last byte → IDLE.
- rx_ready = 1 in IDLE, ADDR and DATA; 0 in REQ, WAIT_R and RESP. Back-pressure is applied to the serial interface during those states; no bytes are lost.
- Reset (anrst low, any state, including mid-command or mid-response):
  - State → IDLE; counter, addr, wdata and the read buffer → 0.
  - Outputs: mem_valid=0, tx_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, tx_data=0, rx_ready=1.
  - Any partial command is discarded.

## Timing
- All outputs are registered, except rx_ready, which is decoded from state.
- Byte accepted at edge N → state/counter update visible at N+1.
- The last command byte accepted at edge N → mem_valid=1 from N+1.
- mem_ready already high at N+1 → transfer at edge N+1.
  - Write: tx_valid=1 with 0x06 from N+2.
  - Read: WAIT_R from N+2.
- mem_rvalid at edge M → tx_valid=1 with rdata[7:0] from M+1.
- Consecutive tx bytes: with tx_ready held high, one byte per cycle.
- Last tx transfer at edge K → IDLE and rx_ready=1 from K+1. Minimum gap is one cycle.
- A byte presented while rx_ready=0 is not consumed; it is accepted once rx_ready returns to 1.

## Configuration
- LADYBIRD_LOADER_TIMEOUT_EN defined:
  - A counter increments each cycle in ADDR or DATA with no byte transfer, and clears on every byte transfer.
  - When it reaches TIMEOUT-1, the state returns to IDLE next cycle, the partial command is discarded, and no response is sent.
- Not defined: no timeout logic is synthesized; the loader waits indefinitely in ADDR/DATA.

## Test plan
- Write: send 57 78 56 34 12 EF BE AD DE with mem_ready=1 → one request with addr=0x12345678, wdata=0xDEADBEEF, we=1; then tx byte 06.
- Read: send 52 00 01 00 00; mem_rvalid 3 cycles after accept with rdata=0xCAFEBABE → one request with addr=0x00000100, we=0; tx bytes BE BA FE CA in order.
- Stalls: mem_ready low for 5 cycles and tx_ready toggling → mem_addr/wdata/tx_data stable while unaccepted; rx_ready=0 throughout; exactly one request and no lost or duplicated bytes.
- Junk and back-to-back: send 00 FF 41, then two read commands with no gap → junk bytes dropped; two requests and 8 response bytes in order.
- Reset mid-command: assert anrst after 57 12 34; then send a full read of 0x00000004 → no request from the partial command; read of 0x00000004 issued correctly.
- Timeout (macro defined, TIMEOUT=100): send 57 01 then idle 100 cycles; then send 52 04 00 00 00 → no write request; read of 0x00000004 issued.

Source files
------------

// File: rtl/ladybird_serial_loader.sv
// ladybird_serial_loader: byte-stream command decoder between the UART and memory.
// Commands: 'W' a0 a1 a2 a3 d0 d1 d2 d3 -> write, replies 0x06.
//           'R' a0 a1 a2 a3             -> read, replies the 4 data bytes LSB first.
// Optional inter-byte timeout in ADDR/DATA, enabled by defining LADYBIRD_LOADER_TIMEOUT_EN.
module ladybird_serial_loader #(
   parameter int unsigned TIMEOUT = 32'd10_000_000
) (
   input  logic        clk,
   input  logic        anrst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_valid,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_REQ,
      S_WAIT_R,
      S_RESP
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RESP_ACK  = 8'h06;

   state_t      state;
   logic [1:0]  cnt;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [23:0] rbuf;
   logic        we;
   logic        rx_fire;
   logic        tx_fire;
   logic        mem_fire;

   // A zero timeout would make the ADDR/DATA states unusable
   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("ladybird_serial_loader: TIMEOUT must be non-zero");
   end

   // Serial side is only accepted while a command is being assembled
   assign rx_ready = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
   assign rx_fire  = rx_valid && rx_ready;
   assign tx_fire  = tx_valid && tx_ready;
   assign mem_fire = mem_valid && mem_ready;

   // Request payload comes straight from the assembly registers; they are frozen outside ADDR/DATA
   assign mem_addr  = addr;
   assign mem_wdata = wdata;
   assign mem_we    = we;

`ifdef LADYBIRD_LOADER_TIMEOUT_EN
   logic [31:0] tmo_cnt;
   logic        tmo_hit;

   assign tmo_hit = ((state == S_ADDR) || (state == S_DATA)) && !rx_fire &&
                    (tmo_cnt == 32'(TIMEOUT - 1));

   // Idle-cycle counter while a command is partially received
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         tmo_cnt <= '0;
      end else if (((state == S_ADDR) || (state == S_DATA)) && !rx_fire && !tmo_hit) begin
         tmo_cnt <= tmo_cnt + 32'd1;
      end else begin
         tmo_cnt <= '0;
      end
   end
`endif

   // Command decoder FSM with registered request/response outputs
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         addr      <= '0;
         wdata     <= '0;
         rbuf      <= '0;
         we        <= 1'b0;
         mem_valid <= 1'b0;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rx_fire && (rx_data == CMD_WRITE)) begin
                  we    <= 1'b1;
                  cnt   <= '0;
                  state <= S_ADDR;
               end else if (rx_fire && (rx_data == CMD_READ)) begin
                  we    <= 1'b0;
                  cnt   <= '0;
                  state <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (rx_fire) begin
                  addr[{cnt, 3'b000} +: 8] <= rx_data;
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     if (we) begin
                        state <= S_DATA;
                     end else begin
                        state     <= S_REQ;
                        mem_valid <= 1'b1;
                     end
                  end
               end
            end
            S_DATA: begin
               if (rx_fire) begin
                  wdata[{cnt, 3'b000} +: 8] <= rx_data;
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     state     <= S_REQ;
                     mem_valid <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (mem_fire) begin
                  mem_valid <= 1'b0;
                  if (we) begin
                     tx_valid <= 1'b1;
                     tx_data  <= RESP_ACK;
                     cnt      <= '0;
                     state    <= S_RESP;
                  end else begin
                     state <= S_WAIT_R;
                  end
               end
            end
            S_WAIT_R: begin
               if (mem_rvalid) begin
                  tx_valid <= 1'b1;
                  tx_data  <= mem_rdata[7:0];
                  rbuf     <= mem_rdata[31:8];
                  cnt      <= '0;
                  state    <= S_RESP;
               end
            end
            S_RESP: begin
               if (tx_fire) begin
                  if (we || (cnt == 2'd3)) begin
                     tx_valid <= 1'b0;
                     cnt      <= '0;
                     state    <= S_IDLE;
                  end else begin
                     cnt     <= cnt + 2'd1;
                     tx_data <= rbuf[7:0];
                     rbuf    <= {8'h00, rbuf[23:8]};
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
`ifdef LADYBIRD_LOADER_TIMEOUT_EN
         // Abandon a stalled partial command without responding
         if (tmo_hit) begin
            state <= S_IDLE;
            cnt   <= '0;
            addr  <= '0;
            wdata <= '0;
            we    <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_ladybird_serial_loader.sv
// Bench for ladybird_serial_loader: byte streams are parsed into expected memory
// requests and response bytes, which a per-cycle monitor compares against the DUT.
module tb_ladybird_serial_loader;

   typedef byte unsigned bq_t[$];
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
   } req_t;

   localparam int unsigned TMO = 100;

   logic        clk;
   logic        anrst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;

   ladybird_serial_loader #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .anrst      (anrst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state and bench bookkeeping
   bq_t          rxq;
   req_t         exp_req[$];
   byte unsigned exp_tx[$];
   byte unsigned captured_tx[$];
   req_t         last_req;
   bit           hold = 1'b1;
   bit           rx_xfer = 1'b0;
   bit           rx_gaps = 1'b0;
   bit           spurious = 1'b0;
   int           ready_mode = 0;
   int           txr_mode = 0;
   int           rd_delay = 3;
   bit           rd_pend = 1'b0;
   int           rd_cd = 0;
   logic [31:0]  rd_addr = '0;
   bit           rv_real = 1'b0;
   int           stall_left = 5;
   int           cyc = 0;
   int           rx_last_cyc = 0;
   int           mv_rise_cyc = 0;
   int           tx_rise_cyc = 0;
   int           tx_last_cyc = 0;
   int           rv_cyc = 0;
   int           req_count = 0;
   int           tx_count = 0;
   bit           rdy_chk_pending = 1'b0;
   logic         last_rdy_after_tx = 1'b0;

   // Memory contents seen by reads
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hCAFE_BABE;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", name, got, exp);
      end
   endtask

   // Turn a byte stream into the requests and reply bytes it must produce
   function automatic void model_stream(input bq_t q);
      int   i = 0;
      req_t r;
      logic [31:0] d;
      while (i < q.size()) begin
         if (q[i] == 8'h57 && i + 8 < q.size()) begin
            r.we    = 1'b1;
            r.addr  = {q[i+4], q[i+3], q[i+2], q[i+1]};
            r.wdata = {q[i+8], q[i+7], q[i+6], q[i+5]};
            exp_req.push_back(r);
            exp_tx.push_back(8'h06);
            i += 9;
         end else if (q[i] == 8'h52 && i + 4 < q.size()) begin
            r.we    = 1'b0;
            r.addr  = {q[i+4], q[i+3], q[i+2], q[i+1]};
            r.wdata = '0;
            exp_req.push_back(r);
            d = mem_fn(r.addr);
            for (int k = 0; k < 4; k++) exp_tx.push_back(8'(d >> (8 * k)));
            i += 5;
         end else begin
            i += 1;
         end
      end
   endfunction

   task automatic send_raw(input bq_t q);
      foreach (q[k]) rxq.push_back(q[k]);
   endtask

   task automatic send(input bq_t q);
      model_stream(q);
      send_raw(q);
   endtask

   function automatic bq_t gen_cmd();
      bq_t q;
      byte unsigned j;
      int nj = int'($urandom_range(0, 2));
      for (int k = 0; k < nj; k++) begin
         j = 8'($urandom);
         if (j == 8'h57 || j == 8'h52) j = 8'h00;
         q.push_back(j);
      end
      if ($urandom_range(0, 1) == 1) begin
         q.push_back(8'h57);
         for (int k = 0; k < 8; k++) q.push_back(8'($urandom));
      end else begin
         q.push_back(8'h52);
         for (int k = 0; k < 4; k++) q.push_back(8'($urandom));
      end
      return q;
   endfunction

   // Input driver: serial source, memory responder and serial sink
   initial begin
      rx_valid   = 1'b0;
      rx_data    = '0;
      tx_ready   = 1'b0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         rv_real = 1'b0;
         if (hold) begin
            rx_valid   = 1'b0;
            tx_ready   = 1'b0;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            rx_xfer    = 1'b0;
            rd_pend    = 1'b0;
            stall_left = 5;
         end else begin
            if (rx_xfer) begin
               void'(rxq.pop_front());
               rx_xfer  = 1'b0;
               rx_valid = 1'b0;
            end
            if (!rx_valid) begin
               if (rxq.size() > 0 && (!rx_gaps || $urandom_range(0, 3) != 0)) begin
                  rx_valid = 1'b1;
                  rx_data  = rxq[0];
               end else begin
                  rx_data = 8'($urandom);
               end
            end
            case (ready_mode)
               0: mem_ready = 1'b1;
               1: mem_ready = 1'($urandom_range(0, 1));
               default: begin
                  if (!mem_valid) begin
                     stall_left = 5;
                     mem_ready  = 1'b1;
                  end else if (stall_left > 0) begin
                     stall_left--;
                     mem_ready = 1'b0;
                  end else begin
                     mem_ready = 1'b1;
                  end
               end
            endcase
            case (txr_mode)
               0: tx_ready = 1'b1;
               1: tx_ready = ~tx_ready;
               default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            mem_rvalid = 1'b0;
            if (rd_pend) begin
               rd_cd--;
               if (rd_cd == 0) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = mem_fn(rd_addr);
                  rd_pend    = 1'b0;
                  rv_real    = 1'b1;
               end
            end else if (spurious && $urandom_range(0, 5) == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = $urandom;
            end
         end
      end
   end

   // Monitor: compares every transfer against the model and checks hold rules
   initial begin
      bit          mv_stall = 1'b0;
      bit          tx_stall = 1'b0;
      bit          mv_prev = 1'b0;
      bit          tx_prev = 1'b0;
      req_t        mv_hold;
      logic [7:0]  tx_hold;
      req_t        e;
      mv_hold = '0;
      tx_hold = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (hold || !anrst) begin
            mv_stall = 1'b0;
            tx_stall = 1'b0;
            mv_prev  = 1'b0;
            tx_prev  = 1'b0;
            rdy_chk_pending = 1'b0;
         end else begin
            if (rdy_chk_pending) begin
               last_rdy_after_tx = rx_ready;
               rdy_chk_pending   = 1'b0;
            end
            if (rx_valid && rx_ready) begin
               rx_xfer     = 1'b1;
               rx_last_cyc = cyc;
            end
            if (mem_valid || tx_valid || rd_pend) chk("rx_ready_busy", 32'(rx_ready), 32'h0);
            if (mv_stall) begin
               chk("mem_valid_hold", 32'(mem_valid), 32'h1);
               chk("mem_addr_hold", mem_addr, mv_hold.addr);
               chk("mem_wdata_hold", mem_wdata, mv_hold.wdata);
               chk("mem_we_hold", 32'(mem_we), 32'(mv_hold.we));
            end
            if (mem_valid && mem_ready) begin
               req_count++;
               last_req = '{addr: mem_addr, wdata: mem_wdata, we: mem_we};
               if (exp_req.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL mem_req unexpected addr=%08h we=%0d", mem_addr, mem_we);
               end else begin
                  e = exp_req.pop_front();
                  chk("req_we", 32'(mem_we), 32'(e.we));
                  chk("req_addr", mem_addr, e.addr);
                  if (e.we) chk("req_wdata", mem_wdata, e.wdata);
               end
               if (!mem_we) begin
                  rd_pend = 1'b1;
                  rd_addr = mem_addr;
                  rd_cd   = (rd_delay != 0) ? rd_delay : int'($urandom_range(1, 5));
               end
            end
            if (mem_valid && !mv_prev) mv_rise_cyc = cyc;
            mv_stall = mem_valid && !mem_ready;
            mv_hold  = '{addr: mem_addr, wdata: mem_wdata, we: mem_we};
            mv_prev  = mem_valid;
            if (mem_rvalid && rv_real) rv_cyc = cyc;
            if (tx_stall) begin
               chk("tx_valid_hold", 32'(tx_valid), 32'h1);
               chk("tx_data_hold", 32'(tx_data), 32'(tx_hold));
            end
            if (tx_valid && tx_ready) begin
               tx_count++;
               captured_tx.push_back(tx_data);
               tx_last_cyc     = cyc;
               rdy_chk_pending = 1'b1;
               if (exp_tx.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_byte unexpected got=%02h", tx_data);
               end else begin
                  chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
               end
            end
            if (tx_valid && !tx_prev) tx_rise_cyc = cyc;
            tx_stall = tx_valid && !tx_ready;
            tx_hold  = tx_data;
            tx_prev  = tx_valid;
         end
      end
   end

   task automatic check_reset_vals();
      chk("rst_mem_valid", 32'(mem_valid), 32'h0);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      chk("rst_rx_ready", 32'(rx_ready), 32'h1);
   endtask

   task automatic do_reset();
      hold = 1'b1;
      @(posedge clk);
      #3;
      anrst = 1'b0;
      @(negedge clk);
      check_reset_vals();
      @(posedge clk);
      #3;
      anrst = 1'b1;
      rxq.delete();
      exp_req.delete();
      exp_tx.delete();
      hold = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      bit done = 1'b0;
      while (!done && n < budget) begin
         @(negedge clk);
         #1;
         n++;
         done = (rxq.size() == 0) && (exp_req.size() == 0) && (exp_tx.size() == 0) &&
                !rd_pend && !mem_valid && !tx_valid && !rx_valid;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s did not drain: got reqs_left=%0d tx_left=%0d rx_left=%0d, need 0",
                  name, exp_req.size(), exp_tx.size(), rxq.size());
      end
   endtask

   task automatic wait_rx_empty(input string name);
      int n = 0;
      while ((rxq.size() != 0 || rx_valid) && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(name, 32'(rxq.size()), 32'h0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t q;
      int  rc0;
      int  tc0;
      anrst = 1'b1;
      #2;
      anrst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals();
      @(posedge clk);
      #3;
      anrst = 1'b1;
      hold  = 1'b0;

      // Directed write with always-ready handshakes
      rx_gaps = 1'b0; ready_mode = 0; txr_mode = 0; rd_delay = 3; spurious = 1'b0;
      rc0 = req_count; captured_tx.delete();
      q = {8'h57, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send(q);
      wait_idle("write", 300);
      chk("w_addr", last_req.addr, 32'h1234_5678);
      chk("w_wdata", last_req.wdata, 32'hDEAD_BEEF);
      chk("w_we", 32'(last_req.we), 32'h1);
      chk("w_reqs", 32'(req_count - rc0), 32'h1);
      chk("w_tx_count", 32'(captured_tx.size()), 32'h1);
      if (captured_tx.size() > 0) chk("w_tx_ack", 32'(captured_tx[0]), 32'h06);
      chk("w_req_latency", 32'(mv_rise_cyc - rx_last_cyc), 32'h1);
      chk("w_ack_latency", 32'(tx_rise_cyc - rx_last_cyc), 32'h2);

      // Directed read, data returned 3 cycles after the request is accepted
      rc0 = req_count; captured_tx.delete();
      q = {8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
      send(q);
      wait_idle("read", 300);
      chk("r_addr", last_req.addr, 32'h0000_0100);
      chk("r_we", 32'(last_req.we), 32'h0);
      chk("r_reqs", 32'(req_count - rc0), 32'h1);
      chk("r_tx_count", 32'(captured_tx.size()), 32'h4);
      if (captured_tx.size() == 4)
         chk("r_tx_bytes", {captured_tx[0], captured_tx[1], captured_tx[2], captured_tx[3]},
             32'hBEBA_FECA);
      chk("r_resp_latency", 32'(tx_rise_cyc - rv_cyc), 32'h1);
      chk("r_resp_burst", 32'(tx_last_cyc - tx_rise_cyc), 32'h3);
      chk("r_rx_ready_after", 32'(last_rdy_after_tx), 32'h1);

      // Stalls on both the memory and the serial transmit side
      ready_mode = 2; txr_mode = 1;
      rc0 = req_count; tc0 = tx_count;
      q = {8'h57, 8'h10, 8'h20, 8'h30, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04,
           8'h52, 8'h08, 8'h00, 8'h00, 8'h80};
      send(q);
      wait_idle("stall", 500);
      chk("s_reqs", 32'(req_count - rc0), 32'h2);
      chk("s_tx_count", 32'(tx_count - tc0), 32'h5);

      // Junk bytes followed by back-to-back reads
      ready_mode = 0; txr_mode = 0;
      rc0 = req_count; tc0 = tx_count;
      q = {8'h00, 8'hFF, 8'h41, 8'h52, 8'h00, 8'h02, 8'h00, 8'h00,
           8'h52, 8'h00, 8'h03, 8'h00, 8'h00};
      send(q);
      wait_idle("junk", 500);
      chk("j_reqs", 32'(req_count - rc0), 32'h2);
      chk("j_tx_count", 32'(tx_count - tc0), 32'h8);

      // Reset in the middle of a write command
      q = {8'h57, 8'h12, 8'h34};
      send_raw(q);
      wait_rx_empty("m_partial_sent");
      do_reset();
      rc0 = req_count;
      q = {8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
      send(q);
      wait_idle("mid_reset", 300);
      chk("m_reqs", 32'(req_count - rc0), 32'h1);
      chk("m_addr", last_req.addr, 32'h0000_0004);
      chk("m_we", 32'(last_req.we), 32'h0);

`ifdef LADYBIRD_LOADER_TIMEOUT_EN
      // Partial write abandoned after TIMEOUT idle cycles
      rc0 = req_count;
      q = {8'h57, 8'h01};
      send_raw(q);
      wait_rx_empty("t_partial_sent");
      repeat (TMO) @(posedge clk);
      q = {8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
      send(q);
      wait_idle("timeout", 300);
      chk("t_reqs", 32'(req_count - rc0), 32'h1);
      chk("t_addr", last_req.addr, 32'h0000_0004);
      chk("t_we", 32'(last_req.we), 32'h0);
`endif

      // Randomized commands, gaps, back-pressure and stray read-valid pulses
      rx_gaps = 1'b1; ready_mode = 1; txr_mode = 2; rd_delay = 0; spurious = 1'b1;
      rc0 = req_count;
      for (int n = 0; n < 40; n++) send(gen_cmd());
      wait_idle("random", 20000);
      chk("rand_reqs", 32'(req_count - rc0), 32'd40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
